// File: rtl/jam_param.sv
// jam_param: exhaustive search of all N! worker-to-job assignments against an external cost memory.
// Build option JAM_PARAM_PRUNE_EN: abandon a permutation once its partial sum exceeds MinCost.
module jam_param #(
  parameter int  N   = 8,
  parameter int  CW  = 7,
  parameter int  MCW = 16,
  localparam int IW  = (N > 2) ? $clog2(N) : 1,
  localparam int SW  = CW + $clog2(N) + 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  output logic [IW-1:0]  W,
  output logic [IW-1:0]  J,
  output logic           req,
  input  logic [CW-1:0]  Cost,
  input  logic           cost_vld,
  output logic           busy,
  output logic [SW-1:0]  MinCost,
  output logic [MCW-1:0] MatchCount,
  output logic           Valid
);

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  perm_q [N];
  logic [IW-1:0]  perm_d [N];
  logic [IW-1:0]  perm_nxt [N];
  logic [IW-1:0]  tmp [N];
  logic [IW-1:0]  idx_q, idx_d, w_q, w_d, j_q, j_d, nidx, pv, sv;
  logic [SW-1:0]  sum_q, sum_d, min_q, min_d, psum;
  logic [MCW-1:0] cnt_q, cnt_d;
  logic           req_q, req_d, busy_q, busy_d, vld_q, vld_d, last;
  int             piv, swp;

  // Lexicographic successor: rightmost ascent, swap with smallest larger suffix entry, reverse suffix.
  always_comb begin
    piv  = 0;
    swp  = 0;
    last = 1'b1;
    pv   = '0;
    sv   = '0;
    for (int i = 0; i < N-1; i++)
      if (perm_q[i] < perm_q[i+1]) begin
        piv  = i;
        last = 1'b0;
      end
    for (int i = 0; i < N; i++)
      if (i == piv) pv = perm_q[i];
    for (int i = 0; i < N; i++)
      if (i > piv && perm_q[i] > pv) begin
        swp = i;
        sv  = perm_q[i];
      end
    for (int i = 0; i < N; i++)
      tmp[i] = (i == piv) ? sv : (i == swp) ? pv : perm_q[i];
    for (int i = 0; i < N; i++) begin
      perm_nxt[i] = tmp[i];
      for (int m = 0; m < N; m++)
        if (i > piv && m == N + piv - i) perm_nxt[i] = tmp[m];
    end
  end

  always_comb begin
    state_d = state_q;
    perm_d  = perm_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    j_d     = j_q;
    req_d   = req_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    nidx    = idx_q + IW'(1);
    psum    = sum_q + SW'(Cost);
    unique case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        for (int i = 0; i < N; i++) perm_d[i] = IW'(i);
        idx_d  = '0;
        sum_d  = '0;
        min_d  = '1;
        cnt_d  = '0;
        w_d    = '0;
        j_d    = '0;
        req_d  = 1'b1;
        busy_d = 1'b1;
      end
      FETCH: if (cost_vld) begin
        sum_d = psum;
        if (idx_q == IW'(N-1)) begin
          state_d = EVAL;
          req_d   = 1'b0;
        end
`ifdef JAM_PARAM_PRUNE_EN
        else if (min_q != '1 && psum > min_q) begin
          state_d = EVAL;
          req_d   = 1'b0;
        end
`endif
        else begin
          idx_d = nidx;
          w_d   = nidx;
          for (int i = 0; i < N; i++)
            if (IW'(i) == nidx) j_d = perm_q[i];
        end
      end
      EVAL: begin
        if (sum_q < min_q) begin
          min_d = sum_q;
          cnt_d = MCW'(1);
        end else if (sum_q == min_q && cnt_q != '1) begin
          cnt_d = cnt_q + MCW'(1);
        end
        if (last) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          perm_d  = perm_nxt;
          idx_d   = '0;
          sum_d   = '0;
          w_d     = '0;
          j_d     = perm_nxt[0];
          req_d   = 1'b1;
        end
      end
      DONE: begin
        vld_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      for (int i = 0; i < N; i++) perm_q[i] <= IW'(i);
      idx_q  <= '0;
      sum_q  <= '0;
      min_q  <= '1;
      cnt_q  <= '0;
      w_q    <= '0;
      j_q    <= '0;
      req_q  <= 1'b0;
      busy_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      perm_q  <= perm_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      j_q     <= j_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
    end
  end

  assign W          = w_q;
  assign J          = j_q;
  assign req        = req_q;
  assign busy       = busy_q;
  assign MinCost    = min_q;
  assign MatchCount = cnt_q;
  assign Valid      = vld_q;

endmodule
